// File: rtl/systola_plm_load_ctrl.sv
// Load sequencer for the Systola PLM: fetches A (8 x n) then B (n x 8) with a single DMA
// read and unpacks each 32-bit beat into four little-endian byte writes on PLM port 0.
module systola_plm_load_ctrl #(
  parameter int ADDR_W = 11,
  parameter int A_BASE = 0,
  parameter int B_BASE = 512,
  parameter int MAX_N  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       conf_info_depth,
  input  logic              conf_done,
  output logic              dma_read_ctrl_valid,
  input  logic              dma_read_ctrl_ready,
  output logic [31:0]       dma_read_ctrl_data_index,
  output logic [31:0]       dma_read_ctrl_data_length,
  output logic [2:0]        dma_read_ctrl_data_size,
  input  logic              dma_read_chnl_valid,
  input  logic [31:0]       dma_read_chnl_data,
  output logic              dma_read_chnl_ready,
  output logic [ADDR_W-1:0] plm_a,
  output logic [7:0]        plm_d,
  output logic              plm_ce,
  output logic              plm_we,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {IDLE, REQ, RECV, UNPACK, DONE, ERR} state_t;

  state_t      state;
  logic [11:0] half;   // 8*n: bytes per operand region
  logic [11:0] k;      // running byte counter over both operands
  logic [31:0] word;
  logic [1:0]  bsel;   // next byte lane of the latched word

  // Byte counter to PLM address: the first 8n bytes belong to A, the rest to B.
  function automatic logic [ADDR_W-1:0] byte_addr(input logic [11:0] kk,
                                                  input logic [11:0] hh);
    int a;
    if (kk < hh) a = A_BASE + int'(kk);
    else         a = B_BASE + int'(kk) - int'(hh);
    return ADDR_W'(a);
  endfunction

  assign dma_read_ctrl_data_index = 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                     <= IDLE;
      half                      <= '0;
      k                         <= '0;
      word                      <= '0;
      bsel                      <= '0;
      dma_read_ctrl_valid       <= 1'b0;
      dma_read_ctrl_data_length <= '0;
      dma_read_ctrl_data_size   <= '0;
      dma_read_chnl_ready       <= 1'b0;
      plm_a                     <= '0;
      plm_d                     <= '0;
      plm_ce                    <= 1'b0;
      plm_we                    <= 1'b0;
      load_done                 <= 1'b0;
      load_err                  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (conf_done) begin
            if (conf_info_depth == 32'd0 || conf_info_depth > 32'(MAX_N)) begin
              load_err <= 1'b1;
              state    <= ERR;
            end else begin
              load_err                  <= 1'b0;
              half                      <= {conf_info_depth[8:0], 3'b000};
              k                         <= '0;
              bsel                      <= '0;
              dma_read_ctrl_valid       <= 1'b1;
              dma_read_ctrl_data_length <= {conf_info_depth[29:0], 2'b00};
              dma_read_ctrl_data_size   <= 3'b010;
              state                     <= REQ;
            end
          end
        end
        REQ: begin
          if (dma_read_ctrl_ready) begin
            dma_read_ctrl_valid <= 1'b0;
            dma_read_chnl_ready <= 1'b1;
            state               <= RECV;
          end
        end
        RECV: begin
          if (dma_read_chnl_valid) begin
            word                <= dma_read_chnl_data;
            dma_read_chnl_ready <= 1'b0;
            plm_ce              <= 1'b1;
            plm_we              <= 1'b1;
            plm_d               <= dma_read_chnl_data[7:0];
            plm_a               <= byte_addr(k, half);
            k                   <= k + 12'd1;
            bsel                <= 2'd1;
            state               <= UNPACK;
          end
        end
        UNPACK: begin
          // bsel wraps to 0 while the fourth byte is on the port
          if (bsel != 2'd0) begin
            plm_d <= word[{bsel, 3'b000} +: 8];
            plm_a <= byte_addr(k, half);
            k     <= k + 12'd1;
            bsel  <= bsel + 2'd1;
          end else begin
            plm_ce <= 1'b0;
            plm_we <= 1'b0;
            if (k == (half << 1)) begin
              load_done <= 1'b1;
              state     <= DONE;
            end else begin
              dma_read_chnl_ready <= 1'b1;
              state               <= RECV;
            end
          end
        end
        DONE: begin
          k     <= '0;
          bsel  <= '0;
          state <= IDLE;
        end
        ERR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
